// File: rtl/pixel_pkg.sv
// pixel_pkg: shared capture-controller types.
// FSM state encoding and the 10-bit buffered pixel entry layout.
package pixel_pkg;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DROP    = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } pix_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: first-word-fall-through buffer, power-of-two depth (>= 2).
// A push into a full buffer succeeds when a pop happens on the same edge.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on command, captures whole frames into a FWFT FIFO.
// Define FRAME_CAPTURE_SIZE_CHECK_EN to add the sticky size_err output.
module frame_capture_ctrl
  import pixel_pkg::*;
#(
  parameter int W_BITS     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              fval,
  input  logic              lval,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cfg_continuous,
  input  logic [W_BITS-1:0] cfg_width,
  output logic [7:0]        m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              overflow
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
  ,
  output logic              size_err
`endif
);

  cap_state_e        state_q, state_d;
  logic              fval_q, lval_q;
  logic              stop_q, stop_d;
  logic              sof_q, sof_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [W_BITS-1:0] col_q, col_d;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
  logic              serr_q, serr_d;
`endif

  logic       fval_rise, fval_fall, lval_fall;
  logic       pix_hit, can_push, push, pop;
  logic       fifo_full, fifo_empty;
  logic       eol;
  pix_entry_t wr_entry, rd_entry;

  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;
  assign lval_fall = ~lval & lval_q;
  assign pix_hit   = pix_valid & fval & lval;
  assign pop       = ~fifo_empty & m_ready;
  assign can_push  = ~fifo_full | pop;
  assign push      = (state_q == ST_CAPTURE) & pix_hit & can_push;
  assign eol       = (col_q == cfg_width - W_BITS'(1));

  assign wr_entry = '{data: pix_data, sof: sof_q, eol: eol};

  pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk     (clk_fast),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_data     = rd_entry.data;
  assign m_sof      = rd_entry.sof;
  assign m_eol      = rd_entry.eol;
  assign m_valid    = ~fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign overflow   = ovf_q;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
  assign size_err   = serr_q;
`endif

  // State and control registers.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      stop_q  <= 1'b0;
      sof_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      col_q   <= '0;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
      serr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fval_q  <= fval;
      lval_q  <= lval;
      stop_q  <= stop_d;
      sof_q   <= sof_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
      serr_q  <= serr_d;
`endif
    end
  end

  // Next-state, frame accounting and column tracking.
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    sof_d   = sof_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    col_d   = col_q;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
    serr_d  = serr_q;
`endif

    if (lval_fall) begin
      col_d = '0;
    end else if (push && (col_q != '1)) begin
      col_d = col_q + W_BITS'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (cmd_start && !cmd_stop) begin
          state_d = ST_ARMED;
          ovf_d   = 1'b0;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
          serr_d  = 1'b0;
`endif
        end
      end
      ST_ARMED: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (fval_rise) begin
          state_d = ST_CAPTURE;
          sof_d   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (cmd_stop) stop_d = 1'b1;
        if (push) sof_d = 1'b0;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
        if (lval_fall && (col_q != cfg_width)) serr_d = 1'b1;
        if (push && (col_q >= cfg_width))      serr_d = 1'b1;
`endif
        if (pix_hit && !can_push) begin
          ovf_d   = 1'b1;
          state_d = ST_DROP;
        end else if (fval_fall) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          stop_d = 1'b0;
          if (cfg_continuous && !(stop_q || cmd_stop)) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (fval_fall) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: scoreboard bench for the frame capture controller.
// Expected pixels are queued as they are driven and checked on each pop.
module tb_frame_capture_ctrl;

  localparam int W_BITS = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        pix_data = '0;
  logic              pix_valid = 1'b0;
  logic              fval = 1'b0;
  logic              lval = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic              cfg_continuous = 1'b0;
  logic [W_BITS-1:0] cfg_width = 12'd4;
  logic [7:0]        m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic              overflow;
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
  logic              size_err;
`endif

  frame_capture_ctrl #(.W_BITS(W_BITS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_fast       (clk),
    .rst            (rst),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .fval           (fval),
    .lval           (lval),
    .cmd_start      (cmd_start),
    .cmd_stop       (cmd_stop),
    .cfg_continuous (cfg_continuous),
    .cfg_width      (cfg_width),
    .m_data         (m_data),
    .m_sof          (m_sof),
    .m_eol          (m_eol),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .overflow       (overflow)
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
    ,
    .size_err       (size_err)
`endif
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         out_cnt = 0;
  int         done_seen = 0;
  int         seq = 0;
  bit         sof_exp = 1'b0;
  logic [9:0] sb_q[$];
  logic [15:0] exp_cnt = 16'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_seen++;
      if (m_valid) begin
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_out got %h,%b,%b want none", m_data, m_sof, m_eol);
        end else if ({m_data, m_sof, m_eol} !== sb_q[0]) begin
          $display("FAIL out_pixel got %h,%b,%b want %h,%b,%b",
                   m_data, m_sof, m_eol, sb_q[0][9:2], sb_q[0][1], sb_q[0][0]);
        end else begin
          pass_cnt++;
        end
        if (m_ready) begin
          out_cnt++;
          if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
  endtask

  task automatic frame_open();
    fval = 1'b1;
    sof_exp = 1'b1;
    tick();
    tick();
  endtask

  task automatic frame_close();
    fval = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int npix, input int cap_limit,
                           input int stop_at, input int ready_at);
    lval = 1'b1;
    for (int p = 0; p < npix; p++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(seq);
      cmd_stop  = (p == stop_at);
      if (p == ready_at) m_ready = 1'b1;
      if (p < cap_limit) begin
        sb_q.push_back({pix_data, sof_exp, p == int'(cfg_width) - 1});
        sof_exp = 1'b0;
      end
      seq++;
      tick();
    end
    pix_valid = 1'b0;
    cmd_stop  = 1'b0;
    lval      = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_empty(input int n);
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total_cnt += 5;
    if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done);
    else pass_cnt++;
    if (frame_cnt !== 16'd0) $display("FAIL rst_cnt got %0d want 0", frame_cnt);
    else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int o0, d0;
    o0 = out_cnt;
    d0 = done_seen;
    cfg_width = 12'd4;
    cfg_continuous = 1'b0;
    m_ready = 1'b1;
    pulse_start();
    frame_open();
    send_line(4, 4, -1, -1);
    send_line(4, 4, -1, -1);
    frame_close();
    exp_cnt++;
    wait_empty(50);
    @(negedge clk);
    total_cnt += 5;
    if (sb_q.size() != 0) $display("FAIL single_drain got %0d left want 0", sb_q.size());
    else pass_cnt++;
    if (out_cnt - o0 != 8) $display("FAIL single_outs got %0d want 8", out_cnt - o0);
    else pass_cnt++;
    if (done_seen - d0 != 1) $display("FAIL single_done got %0d want 1", done_seen - d0);
    else pass_cnt++;
    if (frame_cnt !== exp_cnt) $display("FAIL single_cnt got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_midframe_arm();
    int o0, d0;
    o0 = out_cnt;
    d0 = done_seen;
    fval = 1'b1;
    tick();
    tick();
    send_line(3, 0, -1, -1);
    pulse_start();
    send_line(3, 0, -1, -1);
    frame_close();
    frame_open();
    send_line(4, 4, -1, -1);
    frame_close();
    exp_cnt++;
    wait_empty(50);
    @(negedge clk);
    total_cnt += 3;
    if (out_cnt - o0 != 4) $display("FAIL midarm_outs got %0d want 4", out_cnt - o0);
    else pass_cnt++;
    if (done_seen - d0 != 1) $display("FAIL midarm_done got %0d want 1", done_seen - d0);
    else pass_cnt++;
    if (frame_cnt !== exp_cnt) $display("FAIL midarm_cnt got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_continuous_stop();
    int o0, d0;
    o0 = out_cnt;
    d0 = done_seen;
    cfg_continuous = 1'b1;
    pulse_start();
    frame_open();
    send_line(4, 4, -1, -1);
    frame_close();
    frame_open();
    send_line(4, 4, 1, -1);
    frame_close();
    exp_cnt += 2;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL cont_busy got %b want 0", busy);
    else pass_cnt++;
    tick();
    frame_open();
    send_line(4, 0, -1, -1);
    frame_close();
    wait_empty(50);
    @(negedge clk);
    total_cnt += 3;
    if (out_cnt - o0 != 8) $display("FAIL cont_outs got %0d want 8", out_cnt - o0);
    else pass_cnt++;
    if (done_seen - d0 != 2) $display("FAIL cont_done got %0d want 2", done_seen - d0);
    else pass_cnt++;
    if (frame_cnt !== exp_cnt) $display("FAIL cont_cnt got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    cfg_continuous = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int o0, d0;
    o0 = out_cnt;
    d0 = done_seen;
    m_ready = 1'b0;
    pulse_start();
    frame_open();
    send_line(6, DEPTH, -1, -1);
    @(negedge clk);
    total_cnt += 2;
    if (busy !== 1'b1) $display("FAIL drop_busy got %b want 1", busy);
    else pass_cnt++;
    if (overflow !== 1'b1) $display("FAIL drop_ovf got %b want 1", overflow);
    else pass_cnt++;
    tick();
    frame_close();
    @(negedge clk);
    total_cnt += 5;
    if (busy !== 1'b0) $display("FAIL ovf_busy got %b want 0", busy);
    else pass_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow);
    else pass_cnt++;
    if (done_seen - d0 != 0) $display("FAIL ovf_done got %0d want 0", done_seen - d0);
    else pass_cnt++;
    if (frame_cnt !== exp_cnt) $display("FAIL ovf_cnt got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    if (m_valid !== 1'b1) $display("FAIL ovf_held got %b want 1", m_valid);
    else pass_cnt++;
    tick();
    m_ready = 1'b1;
    wait_empty(50);
    @(negedge clk);
    total_cnt++;
    if (out_cnt - o0 != DEPTH) $display("FAIL ovf_drain got %0d want %0d", out_cnt - o0, DEPTH);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_full_push_pop();
    int o0;
    o0 = out_cnt;
    cfg_width = 12'd8;
    m_ready = 1'b0;
    pulse_start();
    frame_open();
    send_line(6, 6, -1, DEPTH);
    frame_close();
    exp_cnt++;
    @(negedge clk);
    total_cnt += 2;
    if (overflow !== 1'b0) $display("FAIL fullpp_ovf got %b want 0", overflow);
    else pass_cnt++;
    if (frame_cnt !== exp_cnt) $display("FAIL fullpp_cnt got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    tick();
    wait_empty(50);
    @(negedge clk);
    total_cnt++;
    if (out_cnt - o0 != 6) $display("FAIL fullpp_outs got %0d want 6", out_cnt - o0);
    else pass_cnt++;
    cfg_width = 12'd4;
    tick();
  endtask

  task automatic test_reset_midframe();
    int o0;
    m_ready = 1'b0;
    pulse_start();
    frame_open();
    lval = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(seq);
      seq++;
      if (p < 2) begin
        sb_q.push_back({pix_data, sof_exp, 1'b0});
        sof_exp = 1'b0;
      end else begin
        rst = 1'b1;
      end
      tick();
    end
    sb_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    total_cnt += 5;
    if (m_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", m_valid);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy);
    else pass_cnt++;
    if (frame_cnt !== 16'd0) $display("FAIL rstmid_cnt got %0d want 0", frame_cnt);
    else pass_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rstmid_done got %b want 0", frame_done);
    else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", overflow);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    pix_valid = 1'b0;
    lval = 1'b0;
    tick();
    frame_close();
    o0 = out_cnt;
    frame_open();
    send_line(4, 0, -1, -1);
    frame_close();
    @(negedge clk);
    total_cnt += 2;
    if (busy !== 1'b0) $display("FAIL rstmid_idle got %b want 0", busy);
    else pass_cnt++;
    if (out_cnt != o0) $display("FAIL rstmid_nocap got %0d want %0d", out_cnt, o0);
    else pass_cnt++;
    tick();
    pulse_start();
    frame_open();
    send_line(4, 4, -1, -1);
    frame_close();
    exp_cnt++;
    wait_empty(50);
    @(negedge clk);
    total_cnt += 2;
    if (frame_cnt !== exp_cnt) $display("FAIL rstmid_resume got %0d want %0d", frame_cnt, exp_cnt);
    else pass_cnt++;
    if (out_cnt - o0 != 4) $display("FAIL rstmid_outs got %0d want 4", out_cnt - o0);
    else pass_cnt++;
    tick();
  endtask

`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
  task automatic test_size_err();
    cfg_width = 12'd4;
    m_ready = 1'b1;
    pulse_start();
    frame_open();
    send_line(5, 5, -1, -1);
    frame_close();
    wait_empty(50);
    @(negedge clk);
    total_cnt++;
    if (size_err !== 1'b1) $display("FAIL size_set got %b want 1", size_err);
    else pass_cnt++;
    tick();
    pulse_start();
    @(negedge clk);
    total_cnt++;
    if (size_err !== 1'b0) $display("FAIL size_clr got %b want 0", size_err);
    else pass_cnt++;
    tick();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_midframe_arm();
    test_continuous_stop();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
`ifdef FRAME_CAPTURE_SIZE_CHECK_EN
    test_size_err();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter W_BITS, default 12: width of column/row counters and size config.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two): output buffer entries.
REQ-003 SHALL have ports (clock and reset first):
- clk_fast  in  1  sole clock, pixel rate
- rst  in  1  synchronous, active-high reset
- pix_data  in  8  decoded pixel from the receiver
- pix_valid  in  1  pixel strobe, one cycle per pixel
- fval  in  1  frame valid
- lval  in  1  line valid
- cmd_start  in  1  one-cycle pulse; arm capture
- cmd_stop  in  1  one-cycle pulse; stop capture
- cfg_continuous  in  1  1 = re-arm after each frame
- cfg_width  in  W_BITS  pixels per line
- m_data  out  8  buffered pixel
- m_sof  out  1  first pixel of frame
- m_eol  out  1  last pixel of line
- m_valid  out  1  output data valid
- m_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of each captured frame
- frame_cnt  out  16  captured frames, wraps 0xFFFF->0
- overflow  out  1  sticky; pixel lost to a full FIFO

Function
REQ-004 SHALL implement states IDLE, ARMED, CAPTURE, DROP.
REQ-005 IDLE: cmd_start -> ARMED; clear overflow and size_err.
REQ-006 ARMED: fval rising edge (registered fval 0, current 1) -> CAPTURE; arming mid-frame therefore waits for the next frame.
REQ-007 CAPTURE: push {pix_data, sof, eol} when pix_valid && fval && lval; pixel is pushed on the same edge as pix_valid.
REQ-008 sof SHALL be 1 on the first pushed pixel after entering CAPTURE, 0 otherwise.
REQ-009 Column counter SHALL increment per pushed pixel and clear on lval falling edge; eol = (col == cfg_width-1); col saturates at all-ones.
REQ-010 fval falling edge in CAPTURE: frame_done=1 for one cycle, frame_cnt+1; next state ARMED if cfg_continuous and no stop pending, else IDLE.
REQ-011 cmd_stop in ARMED -> IDLE next cycle; in CAPTURE sets stop_pending, frame completes per REQ-010, then IDLE.
REQ-012 cmd_start and cmd_stop in the same cycle: stop wins; cmd_start outside IDLE ignored.
REQ-013 Push while FIFO full: pixel discarded, overflow=1, state -> DROP; DROP discards all pixels until fval falls, then IDLE, no frame_done, frame_cnt unchanged.
REQ-014 FIFO: first-word-fall-through; m_valid = not empty; pop on m_valid && m_ready; simultaneous push and pop when full SHALL succeed (no overflow).
REQ-015 m_data/m_sof/m_eol SHALL hold stable while m_valid && !m_ready.
REQ-016 Leaving CAPTURE SHALL NOT flush the FIFO; buffered pixels drain normally.

Reset
REQ-017 rst SHALL force IDLE, empty FIFO, m_valid=0, busy=0, frame_done=0, frame_cnt=0, overflow=0, size_err=0, stop_pending=0, edge registers=0.
REQ-018 rst mid-frame SHALL drop buffered pixels; after release, capture resumes only via cmd_start and a new fval rise.

Configuration
REQ-019 Macro FRAME_CAPTURE_SIZE_CHECK_EN defined: extra output size_err (1 bit, sticky) set when lval falls with col != cfg_width, or a pixel is pushed with col >= cfg_width; cleared per REQ-005.
REQ-020 Macro undefined: no size_err port, no comparison logic; REQ-009 unchanged.

Structure
REQ-021 State encoding enum and the FIFO entry width (10 bits) SHALL live in shared package pixel_pkg.
REQ-022 FIFO SHALL be a sub-module pixel_fifo (params FIFO_DEPTH, width 10), instantiated once.

Verification
REQ-023 cfg_width=4, single mode, 2x4-pixel frame, m_ready=1 -> 8 outputs, sof on pixel 0, eol on pixels 3 and 7, one frame_done, frame_cnt=1, busy returns to 0.
REQ-024 cmd_start with fval already 1 -> partial frame ignored; capture begins at next fval rise with sof on its first pixel.
REQ-025 Continuous, 3 frames, cmd_stop during frame 2 -> frames 1 and 2 complete, frame_cnt=2, IDLE before frame 3.
REQ-026 m_ready=0, FIFO_DEPTH=4, 6 pixels -> 4 buffered, overflow=1, DROP until fval fall, frame_cnt unchanged; m_ready=1 then drains 4 pixels.
REQ-027 rst asserted at pixel 2 of a frame -> all outputs at reset values next cycle, m_valid=0.
REQ-028 With FRAME_CAPTURE_SIZE_CHECK_EN, cfg_width=4, 5-pixel line -> size_err=1; next cmd_start clears it.
